// File: rtl/shot_pkg.sv
// Shared types, constants and the launch-speed scaling helper for the shot sequencer.
package shot_pkg;

   localparam int ANGLE_STEPS   = 16;
   localparam int DIR_FRAC_BITS = 6;
   localparam int ANGLE_W       = $clog2(ANGLE_STEPS);

   typedef enum logic [2:0] {
      S_AIM      = 3'd0,
      S_CHARGE   = 3'd1,
      S_FIRE     = 3'd2,
      S_ROLLING  = 3'd3,
      S_TURN_END = 3'd4
   } seq_state_t;

   // power (unsigned) times a Q6 direction component, floored back to pixels/64.
   function automatic logic signed [10:0] shot_scale(input logic [7:0] pw,
                                                     input logic signed [7:0] dir);
      logic signed [16:0] prod;
      prod = 17'(signed'({1'b0, pw})) * 17'(dir);
      return 11'(prod >>> DIR_FRAC_BITS);
   endfunction

endpackage

// File: rtl/shot_sequencer_if.sv
// Keypad / ball-motion side signals of the shot sequencer.
interface shot_sequencer_if;

   logic                            startOfFrame;
   logic                            keyRotL;
   logic                            keyRotR;
   logic                            keyShoot;
   logic signed [10:0]              ballXspeed;
   logic signed [10:0]              ballYspeed;
   logic [shot_pkg::ANGLE_W-1:0]    angleIdx;
   logic [7:0]                      power;
   logic                            loadSpeed;
   logic signed [10:0]              shotXspeed;
   logic signed [10:0]              shotYspeed;
   logic                            forceStop;
   logic                            rolling;
   logic                            player;
   logic [7:0]                      shotCount;
   logic [2:0]                      seqState;

   modport master (
      input  startOfFrame, keyRotL, keyRotR, keyShoot, ballXspeed, ballYspeed,
      output angleIdx, power, loadSpeed, shotXspeed, shotYspeed, forceStop,
             rolling, player, shotCount, seqState
   );

   modport slave (
      output startOfFrame, keyRotL, keyRotR, keyShoot, ballXspeed, ballYspeed,
      input  angleIdx, power, loadSpeed, shotXspeed, shotYspeed, forceStop,
             rolling, player, shotCount, seqState
   );

endinterface

// File: rtl/shot_dir_lut.sv
// Aim index to Q6 unit direction: round(64*cos), round(64*sin) at k*22.5 degrees.
module shot_dir_lut
   import shot_pkg::*;
(
   input  logic [ANGLE_W-1:0] angle_idx,
   output logic signed [7:0]  dir_x,
   output logic signed [7:0]  dir_y
);

   // 16-entry direction table, counter-clockwise from +X
   always_comb begin
      dir_x = 8'sd0;
      dir_y = 8'sd0;
      case (angle_idx)
         4'd0:  begin dir_x =  8'sd64; dir_y =  8'sd0;  end
         4'd1:  begin dir_x =  8'sd59; dir_y =  8'sd24; end
         4'd2:  begin dir_x =  8'sd45; dir_y =  8'sd45; end
         4'd3:  begin dir_x =  8'sd24; dir_y =  8'sd59; end
         4'd4:  begin dir_x =  8'sd0;  dir_y =  8'sd64; end
         4'd5:  begin dir_x = -8'sd24; dir_y =  8'sd59; end
         4'd6:  begin dir_x = -8'sd45; dir_y =  8'sd45; end
         4'd7:  begin dir_x = -8'sd59; dir_y =  8'sd24; end
         4'd8:  begin dir_x = -8'sd64; dir_y =  8'sd0;  end
         4'd9:  begin dir_x = -8'sd59; dir_y = -8'sd24; end
         4'd10: begin dir_x = -8'sd45; dir_y = -8'sd45; end
         4'd11: begin dir_x = -8'sd24; dir_y = -8'sd59; end
         4'd12: begin dir_x =  8'sd0;  dir_y = -8'sd64; end
         4'd13: begin dir_x =  8'sd24; dir_y = -8'sd59; end
         4'd14: begin dir_x =  8'sd45; dir_y = -8'sd45; end
         4'd15: begin dir_x =  8'sd59; dir_y = -8'sd24; end
         default: begin dir_x = 8'sd0; dir_y = 8'sd0; end
      endcase
   end

endmodule

// File: rtl/shot_sequencer.sv
// Turn-level controller: aim, charge, fire, watch the ball settle, hand over the turn.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_AIM      | rotate keys move the aim, shoot rise starts charging
// S_CHARGE   | power ramps per frame, shoot release fires (or cancels at 0)
// S_FIRE     | one cycle, loadSpeed pulses with the launch speeds
// S_ROLLING  | wait for SETTLE_FRAMES still frames or the rolling timeout
// S_TURN_END | one cycle, toggle player and count the shot
module shot_sequencer
   import shot_pkg::*;
#(
   parameter int MAX_POWER       = 240,
   parameter int POWER_STEP      = 8,
   parameter int SETTLE_FRAMES   = 15,
   parameter int MAX_ROLL_FRAMES = 600
)(
   input  logic              clk,
   input  logic              resetN,
   shot_sequencer_if.master  bus
);

   localparam int ROLL_W   = $clog2(MAX_ROLL_FRAMES + 1);
   localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);

   seq_state_t           state_q, state_d;
   logic [ANGLE_W-1:0]   angle_q, angle_d;
   logic [7:0]           power_q, power_d;
   logic                 player_q, player_d;
   logic [7:0]           shot_cnt_q, shot_cnt_d;
   logic                 load_q, load_d;
   logic                 force_q, force_d;
   logic                 rolling_q, rolling_d;
   logic signed [10:0]   shot_x_q, shot_x_d;
   logic signed [10:0]   shot_y_q, shot_y_d;
   logic [ROLL_W-1:0]    roll_q, roll_d;
   logic [SETTLE_W-1:0]  settle_q, settle_d;
   logic [2:0]           key_q, key_d;

   logic signed [7:0]    dir_x, dir_y;
   logic                 rise_l, rise_r, rise_s, fall_s, speed_zero;
   logic [8:0]           power_inc;

   shot_dir_lut u_dir_lut (
      .angle_idx (angle_q),
      .dir_x     (dir_x),
      .dir_y     (dir_y)
   );

   // key_q holds last cycle's keys {rotL, rotR, shoot}; edges compare raw input against it
   assign key_d      = {bus.keyRotL, bus.keyRotR, bus.keyShoot};
   assign rise_l     = bus.keyRotL  & ~key_q[2];
   assign rise_r     = bus.keyRotR  & ~key_q[1];
   assign rise_s     = bus.keyShoot & ~key_q[0];
   assign fall_s     = ~bus.keyShoot & key_q[0];
   assign speed_zero = (bus.ballXspeed == 11'sd0) && (bus.ballYspeed == 11'sd0);
   assign power_inc  = {1'b0, power_q} + 9'(POWER_STEP);

   // Next-state and next-output computation; outputs are registered so they line up with state_q
   always_comb begin
      state_d    = state_q;
      angle_d    = angle_q;
      power_d    = power_q;
      player_d   = player_q;
      shot_cnt_d = shot_cnt_q;
      roll_d     = roll_q;
      settle_d   = settle_q;
      force_d    = 1'b0;
      load_d     = 1'b0;
      shot_x_d   = 11'sd0;
      shot_y_d   = 11'sd0;

      case (state_q)
         S_AIM: begin
            if (rise_l && !rise_r)
               angle_d = angle_q + 1'b1;
            else if (rise_r && !rise_l)
               angle_d = angle_q - 1'b1;
            if (rise_s) begin
               power_d = 8'd0;
               state_d = S_CHARGE;
            end
         end
         S_CHARGE: begin
            if (bus.startOfFrame)
               power_d = (power_inc > 9'(MAX_POWER)) ? 8'(MAX_POWER) : power_inc[7:0];
            // release decision deliberately uses the pre-increment power
            if (fall_s)
               state_d = (power_q == 8'd0) ? S_AIM : S_FIRE;
         end
         S_FIRE: begin
            state_d  = S_ROLLING;
            roll_d   = ROLL_W'(MAX_ROLL_FRAMES);
            settle_d = SETTLE_W'(SETTLE_FRAMES);
         end
         S_ROLLING: begin
            if (bus.startOfFrame) begin
               roll_d   = roll_q - 1'b1;
               settle_d = speed_zero ? settle_q - 1'b1 : SETTLE_W'(SETTLE_FRAMES);
               if (speed_zero && settle_q == SETTLE_W'(1)) begin
                  state_d = S_TURN_END;
               end else if (roll_q == ROLL_W'(1)) begin
                  force_d = 1'b1;
                  state_d = S_TURN_END;
               end
            end
         end
         S_TURN_END: begin
            player_d = ~player_q;
            if (shot_cnt_q != 8'hFF)
               shot_cnt_d = shot_cnt_q + 8'd1;
            power_d = 8'd0;
            state_d = S_AIM;
         end
         default: state_d = S_AIM;
      endcase

      if (state_d == S_FIRE) begin
         load_d   = 1'b1;
         shot_x_d = shot_scale(power_d, dir_x);
         shot_y_d = shot_scale(power_d, dir_y);
      end
      rolling_d = (state_d == S_ROLLING);
   end

   // State and output registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= S_AIM;
         angle_q    <= '0;
         power_q    <= '0;
         player_q   <= 1'b0;
         shot_cnt_q <= '0;
         load_q     <= 1'b0;
         force_q    <= 1'b0;
         rolling_q  <= 1'b0;
         shot_x_q   <= '0;
         shot_y_q   <= '0;
         roll_q     <= '0;
         settle_q   <= '0;
         key_q      <= '0;
      end else begin
         state_q    <= state_d;
         angle_q    <= angle_d;
         power_q    <= power_d;
         player_q   <= player_d;
         shot_cnt_q <= shot_cnt_d;
         load_q     <= load_d;
         force_q    <= force_d;
         rolling_q  <= rolling_d;
         shot_x_q   <= shot_x_d;
         shot_y_q   <= shot_y_d;
         roll_q     <= roll_d;
         settle_q   <= settle_d;
         key_q      <= key_d;
      end
   end

   assign bus.angleIdx   = angle_q;
   assign bus.power      = power_q;
   assign bus.loadSpeed  = load_q;
   assign bus.shotXspeed = shot_x_q;
   assign bus.shotYspeed = shot_y_q;
   assign bus.forceStop  = force_q;
   assign bus.rolling    = rolling_q;
   assign bus.player     = player_q;
   assign bus.shotCount  = shot_cnt_q;
   assign bus.seqState   = state_q;

endmodule
